pc_return_stack: RTL and testbench
==================================

Name: pc_return_stack

Overview:
- Program-counter and return-address-stack unit for the small stack CPU.
- Consumes the jump / ret / push strobes produced by the control system and owns the PC register.
- Owns a LIFO of return addresses used for call/return.
- Sits between the control system and instruction memory; its pc output addresses instruction fetch.

Parameters:
AW, 8, PC / address width in bits
DEPTH, 4, return-stack entries (power of two, >= 2)
RESET_VEC, 0, PC value loaded at reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  advance enable; 0 = hold all state
jump  input  1  load pc from jump_addr
ret  input  1  return: load pc from stack top and pop
push  input  1  push return address (pc+1) onto stack
jump_addr  input  AW  jump / call target
pc  output  AW  current program counter (registered)
sp  output  $clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH
stack_empty  output  1  sp == 0 (combinational from sp)
stack_full  output  1  sp == DEPTH (combinational from sp)
ovf  output  1  sticky: push attempted while full
unf  output  1  sticky: ret attempted while empty

Behaviour:
- Reset (rst_n=0 at posedge), which overrides all other inputs:
  - pc=RESET_VEC, sp=0, ovf=0, unf=0.
  - All stack entries cleared to 0.
- en=0: pc, sp, stack contents and flags hold; jump/ret/push are ignored.
- en=1: one action per cycle. Controls are sampled at the posedge; the new pc is visible after that same edge (1-cycle latency, no combinational path from inputs to pc).
- Priority: ret > jump > sequential.
  - ret=1, sp>0: pc <= stack[sp-1]; sp <= sp-1. jump and push are ignored that cycle (ret+jump is the normal return encoding).
  - ret=1, sp==0: unf <= 1; pc <= pc+1; sp unchanged; jump and push are ignored.
  - ret=0, jump=1: pc <= jump_addr.
  - ret=0, jump=0: pc <= pc+1.
- Push, evaluated only when ret=0:
  - sp<DEPTH: stack[sp] <= pc+1 (address of the instruction after the current one); sp <= sp+1.
  - push+jump is a call; push alone saves pc+1 and still increments.
  - sp==DEPTH: ovf <= 1; stack and sp unchanged; the pc update (jump or increment) still occurs.
- Arithmetic:
  - pc+1 is modulo 2^AW (0xFF+1 = 0x00 at AW=8).
  - The pushed value wraps the same way.
- ovf/unf clear only on reset.
- sp never exceeds DEPTH and never underflows below 0.
- Reset asserted mid-sequence (e.g. with a pending call or ret) discards that action; the state next cycle is exactly the reset state.

Test Plan:
1. Reset then 3 cycles of en=1 with no controls -> pc 0x00,0x01,0x02,0x03; sp=0; flags 0. Then preload pc=0xFF via jump_addr=0xFF,jump=1 and step once -> pc=0x00.
2. Call/return: at pc=0x10 apply jump=1,push=1,jump_addr=0x40 -> pc=0x40, sp=1. Step 2 cycles -> pc=0x42. Apply ret=1,jump=1 -> pc=0x11, sp=0, stack_empty=1.
3. Nested overflow (DEPTH=4): 5 consecutive calls from pcs 0x00,0x20,0x30,0x40,0x50 to targets 0x20,0x30,0x40,0x50,0x60 -> after 4th call sp=4, stack_full=1. 5th call -> pc=0x60, sp=4, ovf=1. Four rets -> pc 0x41,0x31,0x21,0x01.
4. Underflow: from reset with pc=0x05 apply ret=1 -> unf=1, pc=0x06, sp=0. Further normal stepping leaves unf=1.
5. Hold and priority: with sp=1, top=0x11, apply en=0 with ret=1 -> no change. Then en=1 with ret=1,push=1,jump=1,jump_addr=0x77 -> pc=0x11, sp=0, no push, ovf=0.
6. Reset mid-operation: with sp=2 and ovf=1, assert rst_n=0 together with a call -> pc=RESET_VEC, sp=0, ovf=0, unf=0. The next ret sets unf=1.

Source files
------------

// File: rtl/pc_return_stack_if.sv
`default_nettype none
// ============================================================================
// pc_return_stack_if : control strobes in, PC / stack status out
// Revision 1.0
// ============================================================================
interface pc_return_stack_if #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) ();
  localparam int SPW = $clog2(DEPTH) + 1;

  logic           en;
  logic           jump;
  logic           ret;
  logic           push;
  logic [AW-1:0]  jump_addr;
  logic [AW-1:0]  pc;
  logic [SPW-1:0] sp;
  logic           stack_empty;
  logic           stack_full;
  logic           ovf;
  logic           unf;

  modport master (
    output en, jump, ret, push, jump_addr,
    input  pc, sp, stack_empty, stack_full, ovf, unf
  );

  modport slave (
    input  en, jump, ret, push, jump_addr,
    output pc, sp, stack_empty, stack_full, ovf, unf
  );
endinterface
`default_nettype wire

// File: rtl/pc_return_stack.sv
`default_nettype none
// ============================================================================
// pc_return_stack : program counter plus LIFO of return addresses
// Revision 1.0
// ============================================================================
module pc_return_stack #(
  parameter int            AW        = 8,
  parameter int            DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_return_stack_if.slave   bus
);
  localparam int             SPW    = $clog2(DEPTH) + 1;
  localparam int             IDXW   = $clog2(DEPTH);
  localparam logic [SPW-1:0] C_FULL = SPW'(DEPTH);

  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [AW-1:0]  stack_q [DEPTH];

  logic [AW-1:0]   pc_inc;
  logic [IDXW-1:0] top_idx;
  logic [IDXW-1:0] wr_idx;
  logic            push_we;
  logic            is_empty;
  logic            is_full;

  assign pc_inc   = pc_q + AW'(1);
  assign top_idx  = IDXW'(sp_q - SPW'(1));
  assign wr_idx   = IDXW'(sp_q);
  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == C_FULL);

  // ret outranks jump; push is only considered when no ret is present
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_we = 1'b0;
    if (bus.en) begin
      if (bus.ret) begin
        if (!is_empty) begin
          pc_d = stack_q[top_idx];
          sp_d = sp_q - SPW'(1);
        end else begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else begin
        pc_d = bus.jump ? bus.jump_addr : pc_inc;
        if (bus.push) begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            push_we = 1'b1;
            sp_d    = sp_q + SPW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stack_q[i] <= '0;
      end else if (push_we && (wr_idx == IDXW'(i))) begin
        stack_q[i] <= pc_inc;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_empty = is_empty;
  assign bus.stack_full  = is_full;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_return_stack.sv
`default_nettype none
// ============================================================================
// tb_pc_return_stack : directed scenarios with hand-computed expectations
// Revision 1.0
// ============================================================================
module tb_pc_return_stack;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_return_stack_if #(.AW(8), .DEPTH(4)) bus ();

  pc_return_stack #(.AW(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, sp, empty, full, ovf, unf}
  logic [14:0] obs;
  assign obs = {bus.pc, bus.sp, bus.stack_empty, bus.stack_full, bus.ovf, bus.unf};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic r, input logic j, input logic p,
                       input logic [7:0] a);
    bus.en        = e;
    bus.ret       = r;
    bus.jump      = j;
    bus.push      = p;
    bus.jump_addr = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== {8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state got %h want %h", obs, {8'h00, 3'd0, 4'b1000});
    end
  endtask

  task automatic test_sequential();
    logic [7:0] exp_pc;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_pc = 8'(i);
      checks++;
      if (obs !== {exp_pc, 3'd0, 4'b1000}) begin
        errors++; $display("FAIL seq_step%0d got %h want %h", i, obs, {exp_pc, 3'd0, 4'b1000});
      end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    step();
    checks++;
    if (bus.pc !== 8'hFF) begin
      errors++; $display("FAIL jump_ff got %h want ff", bus.pc);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    checks++;
    if (obs !== {8'h00, 3'd0, 4'b1000}) begin
      errors++; $display("FAIL pc_wrap got %h want %h", obs, {8'h00, 3'd0, 4'b1000});
    end
  endtask

  task automatic test_call_return();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h10);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h40);
    step();
    checks++;
    if (obs !== {8'h40, 3'd1, 4'b0000}) begin
      errors++; $display("FAIL call got %h want %h", obs, {8'h40, 3'd1, 4'b0000});
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    step();
    checks++;
    if (bus.pc !== 8'h42) begin
      errors++; $display("FAIL callee_step got %h want 42", bus.pc);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
    step();
    checks++;
    if (obs !== {8'h11, 3'd0, 4'b1000}) begin
      errors++; $display("FAIL return got %h want %h", obs, {8'h11, 3'd0, 4'b1000});
    end
  endtask

  task automatic test_overflow();
    logic [7:0] tgt [5];
    logic [7:0] rpc [4];
    tgt = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    rpc = '{8'h41, 8'h31, 8'h21, 8'h01};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, tgt[i]);
      step();
    end
    checks++;
    if (obs !== {8'h50, 3'd4, 4'b0100}) begin
      errors++; $display("FAIL full got %h want %h", obs, {8'h50, 3'd4, 4'b0100});
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, tgt[4]);
    step();
    checks++;
    if (obs !== {8'h60, 3'd4, 4'b0110}) begin
      errors++; $display("FAIL ovf_call got %h want %h", obs, {8'h60, 3'd4, 4'b0110});
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      step();
      checks++;
      if (obs !== {rpc[i], 3'(3 - i), (i == 3), 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL ret%0d got %h want %h", i, obs,
                           {rpc[i], 3'(3 - i), (i == 3), 1'b0, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (5) step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checks++;
    if (obs !== {8'h06, 3'd0, 4'b1001}) begin
      errors++; $display("FAIL unf_ret got %h want %h", obs, {8'h06, 3'd0, 4'b1001});
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    checks++;
    if (obs !== {8'h07, 3'd0, 4'b1001}) begin
      errors++; $display("FAIL unf_sticky got %h want %h", obs, {8'h07, 3'd0, 4'b1001});
    end
  endtask

  task automatic test_hold_priority();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h10);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h40);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checks++;
    if (obs !== {8'h40, 3'd1, 4'b0000}) begin
      errors++; $display("FAIL hold_ret got %h want %h", obs, {8'h40, 3'd1, 4'b0000});
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
    step();
    checks++;
    if (obs !== {8'h40, 3'd1, 4'b0000}) begin
      errors++; $display("FAIL hold_call got %h want %h", obs, {8'h40, 3'd1, 4'b0000});
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
    step();
    checks++;
    if (obs !== {8'h11, 3'd0, 4'b1000}) begin
      errors++; $display("FAIL ret_priority got %h want %h", obs, {8'h11, 3'd0, 4'b1000});
    end
  endtask

  task automatic test_push_wrap();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h30);
    step();
    checks++;
    if (obs !== {8'h30, 3'd1, 4'b0000}) begin
      errors++; $display("FAIL wrap_call got %h want %h", obs, {8'h30, 3'd1, 4'b0000});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checks++;
    if (obs !== {8'h00, 3'd0, 4'b1000}) begin
      errors++; $display("FAIL wrap_ret got %h want %h", obs, {8'h00, 3'd0, 4'b1000});
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] tgt [5];
    tgt = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, tgt[i]);
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    step();
    checks++;
    if (obs !== {8'h31, 3'd2, 4'b0010}) begin
      errors++; $display("FAIL pre_reset got %h want %h", obs, {8'h31, 3'd2, 4'b0010});
    end
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
    step();
    checks++;
    if (obs !== {8'h00, 3'd0, 4'b1000}) begin
      errors++; $display("FAIL mid_reset got %h want %h", obs, {8'h00, 3'd0, 4'b1000});
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checks++;
    if (obs !== {8'h01, 3'd0, 4'b1001}) begin
      errors++; $display("FAIL post_reset_ret got %h want %h", obs, {8'h01, 3'd0, 4'b1001});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    test_reset();
    test_sequential();
    test_call_return();
    test_overflow();
    test_underflow();
    test_hold_priority();
    test_push_wrap();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
